// File: rtl/wash_cycle_ctrl.sv
// Self-timed washing-machine sequencer: soak, wash, drain/rinse passes and spin,
// with pause/door freeze and an abort path that always drains before idling.
module wash_cycle_ctrl #(
  parameter int TW        = 16,
  parameter int SOAK_LO   = 100,
  parameter int SOAK_HI   = 200,
  parameter int WASH_LO   = 300,
  parameter int WASH_HI   = 500,
  parameter int DRAIN_T   = 50,
  parameter int RINSE_T   = 150,
  parameter int SPIN_T    = 250,
  parameter int RC_W      = 2,
  parameter int MAX_RINSE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            select,
  input  logic            stop,
  input  logic            pause,
  input  logic            door_closed,
  input  logic [RC_W-1:0] rinse_cnt,
  output logic            idle,
  output logic            soak_low,
  output logic            soak_high,
  output logic            wash_low,
  output logic            wash_high,
  output logic            drain,
  output logic            rinse,
  output logic            spin,
  output logic            busy,
  output logic            door_lock,
  output logic            paused,
  output logic            done,
  output logic [TW-1:0]   remaining,
  output logic [RC_W-1:0] rinse_left
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOAK,
    S_WASH,
    S_DRAIN,
    S_RINSE,
    S_SPIN
  } state_t;

  // Timer reload values: a phase of D cycles counts D-1 down to 0.
  localparam logic [TW-1:0]   SOAK_LO_LD = TW'(SOAK_LO - 1);
  localparam logic [TW-1:0]   SOAK_HI_LD = TW'(SOAK_HI - 1);
  localparam logic [TW-1:0]   WASH_LO_LD = TW'(WASH_LO - 1);
  localparam logic [TW-1:0]   WASH_HI_LD = TW'(WASH_HI - 1);
  localparam logic [TW-1:0]   DRAIN_LD   = TW'(DRAIN_T - 1);
  localparam logic [TW-1:0]   RINSE_LD   = TW'(RINSE_T - 1);
  localparam logic [TW-1:0]   SPIN_LD    = TW'(SPIN_T - 1);
  localparam logic [RC_W-1:0] RINSE_CAP  = RC_W'(MAX_RINSE);

  state_t          state_reg, state_next;
  logic [TW-1:0]   remaining_reg, remaining_next;
  logic [RC_W-1:0] rinse_left_reg, rinse_left_next;
  logic            hvy_reg, hvy_next;
  logic            abort_reg, abort_next;
  logic            done_reg, done_next;

  logic            busy_int;
  logic            frozen;
  logic            expired;
  logic            abort_eff;
  logic [RC_W-1:0] rinse_req;

  assign busy_int  = (state_reg != S_IDLE);
  assign frozen    = busy_int && (pause || !door_closed);
  assign expired   = (remaining_reg == '0);
  assign abort_eff = abort_reg || stop;
  assign rinse_req = (rinse_cnt > RINSE_CAP) ? RINSE_CAP : rinse_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      remaining_reg  <= '0;
      rinse_left_reg <= '0;
      hvy_reg        <= 1'b0;
      abort_reg      <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      rinse_left_reg <= rinse_left_next;
      hvy_reg        <= hvy_next;
      abort_reg      <= abort_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    rinse_left_next = rinse_left_reg;
    hvy_next        = hvy_reg;
    abort_next      = abort_reg;
    done_next       = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start && door_closed) begin
          state_next      = S_SOAK;
          hvy_next        = select;
          rinse_left_next = rinse_req;
          remaining_next  = select ? SOAK_HI_LD : SOAK_LO_LD;
        end
      end

      // Water is in the drum: an abort must go through a drain first.
      S_SOAK, S_WASH, S_RINSE: begin
        if (stop) begin
          state_next     = S_DRAIN;
          abort_next     = 1'b1;
          remaining_next = DRAIN_LD;
        end else if (!frozen) begin
          if (!expired) begin
            remaining_next = remaining_reg - TW'(1);
          end else if (state_reg == S_SOAK) begin
            state_next     = S_WASH;
            remaining_next = hvy_reg ? WASH_HI_LD : WASH_LO_LD;
          end else begin
            state_next     = S_DRAIN;
            remaining_next = DRAIN_LD;
          end
        end
      end

      S_DRAIN: begin
        abort_next = abort_eff;
        if (!frozen) begin
          if (!expired) begin
            remaining_next = remaining_reg - TW'(1);
          end else if (abort_eff) begin
            state_next      = S_IDLE;
            remaining_next  = '0;
            rinse_left_next = '0;
            abort_next      = 1'b0;
          end else if (rinse_left_reg != '0) begin
            state_next      = S_RINSE;
            rinse_left_next = rinse_left_reg - RC_W'(1);
            remaining_next  = RINSE_LD;
          end else begin
            state_next     = S_SPIN;
            remaining_next = SPIN_LD;
          end
        end
      end

      // The drum is empty while spinning, so an abort can idle immediately.
      S_SPIN: begin
        if (stop) begin
          state_next      = S_IDLE;
          remaining_next  = '0;
          rinse_left_next = '0;
          abort_next      = 1'b0;
        end else if (!frozen) begin
          if (!expired) begin
            remaining_next = remaining_reg - TW'(1);
          end else begin
            state_next      = S_IDLE;
            remaining_next  = '0;
            rinse_left_next = '0;
            abort_next      = 1'b0;
            done_next       = 1'b1;
          end
        end
      end

      default: begin
        state_next     = S_IDLE;
        remaining_next = '0;
      end
    endcase
  end

  assign idle       = (state_reg == S_IDLE);
  assign soak_low   = (state_reg == S_SOAK) && !hvy_reg;
  assign soak_high  = (state_reg == S_SOAK) && hvy_reg;
  assign wash_low   = (state_reg == S_WASH) && !hvy_reg;
  assign wash_high  = (state_reg == S_WASH) && hvy_reg;
  assign drain      = (state_reg == S_DRAIN);
  assign rinse      = (state_reg == S_RINSE);
  assign spin       = (state_reg == S_SPIN);
  assign busy       = busy_int;
  assign door_lock  = busy_int;
  assign paused     = frozen;
  assign done       = done_reg;
  assign remaining  = remaining_reg;
  assign rinse_left = rinse_left_reg;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Bench for wash_cycle_ctrl: directed program scenarios plus random stimulus,
// all checked cycle by cycle against a phase-queue model of the sequencer.
module tb_wash_cycle_ctrl;

  localparam int TW = 16, RC_W = 2, MAX_RINSE = 3;
  localparam int SOAK_LO = 4, SOAK_HI = 8, WASH_LO = 6, WASH_HI = 10;
  localparam int DRAIN_T = 2, RINSE_T = 3, SPIN_T = 5;
  localparam int P_IDLE = 0, P_SOAK = 1, P_WASH = 2, P_DRAIN = 3, P_RINSE = 4, P_SPIN = 5;

  typedef logic [29:0] vec_t;

  logic clk = 1'b0;
  logic rst, start, select, stop, pause, door_closed;
  logic [RC_W-1:0] rinse_cnt;
  logic idle, soak_low, soak_high, wash_low, wash_high, drain, rinse, spin;
  logic busy, door_lock, paused, done;
  logic [TW-1:0] remaining;
  logic [RC_W-1:0] rinse_left;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: current phase, its cycles left, the phases still to come.
  int m_ph = P_IDLE;
  int m_rem = 0;
  int m_rl = 0;
  bit m_hvy = 1'b0;
  bit m_done = 1'b0;
  int m_q[$];

  wash_cycle_ctrl #(
    .TW(TW), .SOAK_LO(SOAK_LO), .SOAK_HI(SOAK_HI), .WASH_LO(WASH_LO),
    .WASH_HI(WASH_HI), .DRAIN_T(DRAIN_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T),
    .RC_W(RC_W), .MAX_RINSE(MAX_RINSE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .stop(stop),
    .pause(pause), .door_closed(door_closed), .rinse_cnt(rinse_cnt),
    .idle(idle), .soak_low(soak_low), .soak_high(soak_high),
    .wash_low(wash_low), .wash_high(wash_high), .drain(drain), .rinse(rinse),
    .spin(spin), .busy(busy), .door_lock(door_lock), .paused(paused),
    .done(done), .remaining(remaining), .rinse_left(rinse_left)
  );

  always #5 clk = ~clk;

  function automatic int dur(int ph, bit h);
    case (ph)
      P_SOAK:  return h ? SOAK_HI : SOAK_LO;
      P_WASH:  return h ? WASH_HI : WASH_LO;
      P_DRAIN: return DRAIN_T;
      P_RINSE: return RINSE_T;
      P_SPIN:  return SPIN_T;
      default: return 0;
    endcase
  endfunction

  // Bit order: idle, soak_low, soak_high, wash_low, wash_high, drain, rinse, spin.
  function automatic logic [7:0] act_vec(int ph, bit h);
    logic [7:0] v;
    v = '0;
    case (ph)
      P_IDLE:  v[7] = 1'b1;
      P_SOAK:  if (h) v[5] = 1'b1; else v[6] = 1'b1;
      P_WASH:  if (h) v[3] = 1'b1; else v[4] = 1'b1;
      P_DRAIN: v[2] = 1'b1;
      P_RINSE: v[1] = 1'b1;
      P_SPIN:  v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic vec_t model_vec();
    bit b;
    b = (m_ph != P_IDLE);
    return {act_vec(m_ph, m_hvy), b, b, b && (pause || !door_closed), m_done,
            TW'(m_rem), RC_W'(m_rl)};
  endfunction

  function automatic vec_t dut_vec();
    return {idle, soak_low, soak_high, wash_low, wash_high, drain, rinse, spin,
            busy, door_lock, paused, done, remaining, rinse_left};
  endfunction

  task automatic model_go_idle();
    m_ph = P_IDLE;
    m_rem = 0;
    m_rl = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    if (rst) begin
      model_go_idle();
      m_hvy = 1'b0;
      m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_ph == P_IDLE) begin
      if (start && door_closed) begin
        m_hvy = select;
        m_rl = (int'(rinse_cnt) > MAX_RINSE) ? MAX_RINSE : int'(rinse_cnt);
        m_q.delete();
        m_q.push_back(P_WASH);
        for (int i = 0; i < m_rl; i++) begin
          m_q.push_back(P_DRAIN);
          m_q.push_back(P_RINSE);
        end
        m_q.push_back(P_DRAIN);
        m_q.push_back(P_SPIN);
        m_ph = P_SOAK;
        m_rem = dur(P_SOAK, m_hvy) - 1;
      end
    end else if (stop && m_ph == P_SPIN) begin
      model_go_idle();
    end else if (stop && m_ph != P_DRAIN) begin
      m_q.delete();
      m_ph = P_DRAIN;
      m_rem = DRAIN_T - 1;
    end else begin
      if (stop) m_q.delete();
      if (!(pause || !door_closed)) begin
        if (m_rem > 0) begin
          m_rem--;
        end else if (m_q.size() == 0) begin
          m_done = (m_ph == P_SPIN);
          model_go_idle();
        end else begin
          m_ph = m_q.pop_front();
          m_rem = dur(m_ph, m_hvy) - 1;
          if (m_ph == P_RINSE) m_rl--;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic quiet_inputs();
    start = 1'b0; stop = 1'b0; pause = 1'b0; door_closed = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      select = 1'($urandom_range(0, 1));
      stop = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    vectors++;
    if ({idle, busy, done, remaining} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_values got idle=%b busy=%b done=%b rem=%0d exp 1 0 0 0",
               idle, busy, done, remaining);
    end
    rst = 1'b0;
    quiet_inputs();
  endtask

  task automatic test_light_one_rinse();
    int t_done, n_done, n_soak, n_wash, n_drain, n_rinse, n_spin;
    bit idle_at_done;
    t_done = -1; n_done = 0; n_soak = 0; n_wash = 0; n_drain = 0; n_rinse = 0; n_spin = 0;
    idle_at_done = 1'b0;
    select = 1'b0; rinse_cnt = 2'd1; start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL light cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (soak_low) n_soak++;
      if (wash_low) n_wash++;
      if (drain) n_drain++;
      if (rinse) n_rinse++;
      if (spin) n_spin++;
      if (done) begin
        n_done++;
        if (t_done < 0) begin
          t_done = t;
          idle_at_done = idle && !busy;
        end
      end
    end
    vectors++;
    if (t_done != 22 || n_done != 1 || !idle_at_done) begin
      miscompares++;
      $display("FAIL light_done got cycle=%0d count=%0d idle=%b exp cycle=22 count=1 idle=1",
               t_done, n_done, idle_at_done);
    end
    vectors++;
    if (n_soak != 4 || n_wash != 6 || n_drain != 4 || n_rinse != 3 || n_spin != 5) begin
      miscompares++;
      $display("FAIL light_phases got %0d/%0d/%0d/%0d/%0d exp 4/6/4/3/5",
               n_soak, n_wash, n_drain, n_rinse, n_spin);
    end
  endtask

  task automatic test_heavy_three_rinse();
    int t_done, n_done, hist, last_rl;
    t_done = -1; n_done = 0; hist = 0; last_rl = -1;
    select = 1'b1; rinse_cnt = 2'd3; start = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL heavy cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (busy && int'(rinse_left) != last_rl) begin
        last_rl = int'(rinse_left);
        hist = hist * 10 + last_rl;
      end
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
    end
    vectors++;
    if (t_done != 40 || n_done != 1 || hist != 3210) begin
      miscompares++;
      $display("FAIL heavy_summary got done_at=%0d count=%0d rl_steps=%0d exp 40 1 3210",
               t_done, n_done, hist);
    end
  endtask

  task automatic test_no_rinse();
    int t_done, n_rinse;
    t_done = -1; n_rinse = 0;
    select = 1'b0; rinse_cnt = 2'd0; start = 1'b1;
    for (int t = 0; t < 25; t++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL no_rinse cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (rinse) n_rinse++;
      if (done && t_done < 0) t_done = t;
    end
    vectors++;
    if (t_done != 17 || n_rinse != 0) begin
      miscompares++;
      $display("FAIL no_rinse_summary got done_at=%0d rinse=%0d exp 17 0", t_done, n_rinse);
    end
  endtask

  // Freeze mid-wash either by pause or by opening the door.
  task automatic test_freeze(input bit use_door);
    bit found;
    found = 1'b0;
    select = 1'b0; rinse_cnt = 2'($urandom_range(0, 3)); start = 1'b1;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL freeze_run cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      found = (m_ph == P_WASH && m_rem == 3);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL freeze_reach got no wash at remaining=3 exp reached within 30 cycles");
    end
    if (use_door) door_closed = 1'b0; else pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      vectors++;
      if (dut_vec() !== model_vec() || wash_low !== 1'b1 || remaining !== 16'd3 || paused !== 1'b1) begin
        miscompares++;
        $display("FAIL freeze_hold door=%0d cyc=%0d got=%h exp=%h", use_door, cyc, dut_vec(), model_vec());
      end
    end
    pause = 1'b0; door_closed = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (dut_vec() !== model_vec() || wash_low !== (k <= 3) || drain !== (k == 4)) begin
        miscompares++;
        $display("FAIL freeze_resume k=%0d got wash=%b drain=%b exp wash=%b drain=%b",
                 k, wash_low, drain, (k <= 3), (k == 4));
      end
    end
    for (int t = 0; t < 40 && m_ph != P_IDLE; t++) begin
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL freeze_finish cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_start_door_open();
    door_closed = 1'b0; start = 1'b1; select = 1'($urandom_range(0, 1));
    rinse_cnt = 2'($urandom_range(0, 3));
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (dut_vec() !== model_vec() || idle !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL door_open_start got idle=%b busy=%b exp idle=1 busy=0", idle, busy);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_stop();
    bit found;
    int n_drain, n_spin, n_done;
    found = 1'b0; n_drain = 0; n_spin = 0; n_done = 0;
    select = 1'b0; rinse_cnt = 2'd2; start = 1'b1;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      start = 1'b0;
      found = (m_ph == P_RINSE);
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL stop_reach got no rinse exp rinse within 30 cycles");
    end
    stop = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      stop = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL stop_rinse cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (drain) n_drain++;
      if (spin) n_spin++;
      if (done) n_done++;
    end
    vectors++;
    if (n_drain != 2 || n_spin != 0 || n_done != 0 || idle !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_rinse_summary got drain=%0d spin=%0d done=%0d idle=%b exp 2 0 0 1",
               n_drain, n_spin, n_done, idle);
    end
    found = 1'b0;
    rinse_cnt = 2'd0; start = 1'b1;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      start = 1'b0;
      found = (m_ph == P_SPIN && m_rem == 2);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if (!found || dut_vec() !== model_vec() || idle !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_spin got idle=%b done=%b reached=%b exp idle=1 done=0 reached=1",
               idle, done, found);
    end
  endtask

  task automatic test_reset_mid_wash();
    bit found;
    int t_done;
    found = 1'b0; t_done = -1;
    select = 1'b1; rinse_cnt = 2'($urandom_range(0, 3)); start = 1'b1;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      start = 1'b0;
      found = (m_ph == P_WASH && m_rem == 4);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (!found || dut_vec() !== model_vec() || idle !== 1'b1 || remaining !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid got idle=%b rem=%0d busy=%b reached=%b exp 1 0 0 1",
               idle, remaining, busy, found);
    end
    select = 1'b0; rinse_cnt = 2'd1; start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tick();
      start = 1'b0;
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL reset_rerun cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (done && t_done < 0) t_done = t;
    end
    vectors++;
    if (t_done != 22) begin
      miscompares++;
      $display("FAIL reset_rerun_done got cycle=%0d exp 22", t_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_done, t_last;
    n_done = 0; t_last = -1;
    select = 1'b0; rinse_cnt = 2'd0; start = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (done) begin
        n_done++;
        t_last = t;
      end
    end
    start = 1'b0;
    vectors++;
    if (n_done != 2 || t_last != 35) begin
      miscompares++;
      $display("FAIL back_to_back_summary got count=%0d last=%0d exp 2 35", n_done, t_last);
    end
    for (int t = 0; t < 40 && m_ph != P_IDLE; t++) tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      select = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 5) == 0);
      door_closed = ($urandom_range(0, 9) != 0);
      rinse_cnt = 2'($urandom_range(0, 3));
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
    quiet_inputs();
  endtask

  initial begin
    rst = 1'b1; select = 1'b0; rinse_cnt = '0;
    quiet_inputs();
    test_reset();
    test_light_one_rinse();
    test_heavy_three_rinse();
    test_no_rinse();
    test_freeze(1'b0);
    test_freeze(1'b1);
    test_start_door_open();
    test_stop();
    test_reset_mid_wash();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
Parametrised, self-timed washing-machine sequencer. It uses internal down-counters in place of externally supplied phase timers. It supports light and heavy programs, a programmable rinse count, pause/resume, door interlock, and a safe abort path that drains water before returning to idle. It sits between the front-panel input logic and the motor/valve drivers. Its activity outputs drive those actuators directly.

Parameters:
TW, 16, width of phase timer and remaining-time output
SOAK_LO, 100, light-program soak duration in cycles (>=1)
SOAK_HI, 200, heavy-program soak duration in cycles (>=1)
WASH_LO, 300, light-program wash duration in cycles (>=1)
WASH_HI, 500, heavy-program wash duration in cycles (>=1)
DRAIN_T, 50, drain duration in cycles (>=1)
RINSE_T, 150, rinse duration in cycles (>=1)
SPIN_T, 250, spin duration in cycles (>=1)
RC_W, 2, width of rinse-count input
MAX_RINSE, 3, clamp value applied to rinse_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin program; honoured only in IDLE with door_closed=1
select  in  1  program: 0=light, 1=heavy; sampled with start
stop  in  1  abort request, level-sensitive
pause  in  1  freeze current phase while high
door_closed  in  1  door sensor, 1=closed
rinse_cnt  in  RC_W  number of rinse passes; sampled with start
idle, soak_low, soak_high, wash_low, wash_high, drain, rinse, spin  out  1 each  one-hot activity outputs
busy  out  1  high in every state except IDLE
door_lock  out  1  equals busy
paused  out  1  timer currently frozen
done  out  1  one-cycle pulse on normal completion
remaining  out  TW  cycles left in current phase
rinse_left  out  RC_W  rinse passes still to run

Behaviour:
- States: IDLE, SOAK, WASH, DRAIN, RINSE, SPIN. Outputs are Moore outputs decoded from the registered state.
- soak_low/soak_high and wash_low/wash_high are selected by the latched mode bit hvy. Exactly one activity output is high at all times.
- Reset values: state=IDLE; idle=1; all other activity outputs=0; busy=0, paused=0, done=0; remaining=0; rinse_left=0; hvy=0; abort flag=0.
- Start: in IDLE with start=1 and door_closed=1 at edge k, the block latches hvy=select and rinse_left=min(rinse_cnt,MAX_RINSE). State becomes SOAK at edge k.
- start is ignored outside IDLE, and ignored in IDLE when door_closed=0.
- Phase timer: on entry to a phase, remaining loads D-1, where D is that phase's duration. Each unfrozen cycle it decrements. At remaining=0 and unfrozen, the next edge moves to the next phase. Every phase therefore lasts exactly D unfrozen cycles.
- Normal sequence: SOAK -> WASH -> DRAIN.
  - DRAIN with rinse_left>0 and abort=0 -> RINSE. rinse_left decrements on RINSE entry.
  - DRAIN with rinse_left=0 and abort=0 -> SPIN.
  - RINSE -> DRAIN.
  - SPIN -> IDLE, with done=1 for exactly the first IDLE cycle.
- Freeze: the timer is frozen when pause=1 or door_closed=0 while busy. paused mirrors the freeze condition.
  - The state does not change while frozen. Activity outputs stay asserted.
  - Resume continues from the held remaining value.
- Abort (stop=1, sampled each edge while busy; priority stop > freeze > expiry):
  - SOAK, WASH or RINSE: next edge -> DRAIN with abort=1. remaining loads DRAIN_T-1.
  - DRAIN: abort=1 is set; the drain continues to expiry.
  - DRAIN with abort=1 expiring -> IDLE. done=0, rinse_left cleared.
  - SPIN: next edge -> IDLE, done=0.
  - abort clears on IDLE entry.
- stop in IDLE has no effect. stop while frozen is still honoured, and the abort drain runs only when unfrozen.
- rinse_cnt=0 skips RINSE entirely. rinse_cnt above MAX_RINSE is clamped.
- rst=1 at any edge forces the reset values at that edge, regardless of state or other inputs. No done pulse is produced.
- Timer arithmetic is unsigned TW bits. Durations must fit in TW and must be >=1; a 0 duration is illegal and unchecked.

Test Plan:
Overrides for all scenarios: SOAK_LO=4, SOAK_HI=8, WASH_LO=6, WASH_HI=10, DRAIN_T=2, RINSE_T=3, SPIN_T=5.
- Light program, rinse_cnt=1, start pulse at edge 0 -> soak_low 4 cycles, wash_low 6, drain 2, rinse 3, drain 2, spin 5. done=1 in cycle 22 only, with idle=1 and busy=0.
- Heavy program, rinse_cnt=3 -> soak_high 8, wash_high 10, then drain/rinse alternating three times, final drain 2, spin 5. rinse_left steps 3,2,1,0. done fires once.
- Light program, rinse_cnt=0 -> DRAIN goes directly to SPIN; no rinse cycle. Total 17 cycles to done.
- pause held 7 cycles mid-WASH at remaining=3 -> wash_low stays high, remaining holds 3, paused=1. The phase completes 3 cycles after release.
- Same check with door_closed=0 instead of pause -> identical freeze. Separately, start with door_closed=0 in IDLE -> no transition.
- stop during RINSE -> DRAIN for exactly 2 cycles, then IDLE, no SPIN, done=0. stop in SPIN -> IDLE next edge.
- rst asserted mid-WASH -> idle=1, remaining=0, busy=0 at that edge. A later start runs the full sequence normally.
